// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared constants and types for the packet-buffer memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 128;
  localparam int DEPTH_DEF   = 256;
  localparam int ADDR_W_DEF  = $clog2(DEPTH_DEF);

  // Top-level sequencer state: normal arbitration or bulk zero-fill.
  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. The search starts at ptr_i and
//            wraps; the first valid requester found wins. The pointer register
//            itself lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               en_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Rotating priority search: walk NUM_REQ slots starting at the pointer.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (en_i && !found && valid_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single packet-buffer memory port among NUM_REQ
//            requesters with round-robin grants, returns read data one cycle
//            after the grant, and runs a bulk zero-fill sequencer on command.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_rdata,
  input  logic                      clear_req,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WIDTH-1:0]          mem_data_in,
  output logic                      mem_write_en,
  output logic                      mem_read_en,
  input  logic [WIDTH-1:0]          mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 clear_busy_q, clear_busy_d;
  logic                 clear_done_q, clear_done_d;

  logic                 arb_en;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 gnt_any;
  logic                 gnt_we;
  logic                 clr_last;

  // Grants only exist in ARB and never while reset is held.
  assign arb_en   = reset_n && (state_q == ARB);
  assign gnt_any  = |grant;
  assign gnt_we   = req_we[grant_idx];
  assign clr_last = (clr_addr_q == LAST_ADDR);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .valid_i (req_valid),
    .en_i    (arb_en),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = mem_data_out;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

  // State register and all other sequential state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      clr_addr_q   <= '0;
      rsp_valid_q  <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_addr_q   <= clr_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Next-state logic: FSM transitions, clear counter, pointer and response.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = '0;
    rr_ptr_d     = rr_ptr_q;
    clear_done_d = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_req) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_d      = ARB;
          clear_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
    // The grant vector is already empty outside ARB, so CLEAR leaves the
    // pointer alone and any read granted in the sampling cycle still answers.
    if (gnt_any) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
    rsp_valid_d  = grant & ~req_we;
    clear_busy_d = (state_d == CLEAR);
  end

  // Memory-port mux: clear sequencer or the winning requester.
  always_comb begin
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    if (reset_n) begin
      if (state_q == CLEAR) begin
        mem_addr     = clr_addr_q;
        mem_write_en = 1'b1;
      end else if (gnt_any) begin
        mem_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        if (gnt_we) begin
          mem_write_en = 1'b1;
          mem_data_in  = req_wdata[int'(grant_idx)*WIDTH +: WIDTH];
        end else begin
          mem_read_en = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a behavioural
//            single-port memory (registered read) attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_we;
  logic [31:0]  req_addr;
  logic [511:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_rdata;
  logic         clear_req;
  logic         clear_busy;
  logic         clear_done;
  logic [7:0]   mem_addr;
  logic [127:0] mem_data_in;
  logic         mem_write_en;
  logic         mem_read_en;
  logic [127:0] mem_data_out;

  int errors = 0;
  int checks = 0;

  logic [127:0] mem_model [256];

  always #5 clk = ~clk;

  // Single-port memory, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_write_en) mem_model[mem_addr] <= mem_data_in;
    if (mem_read_en)  mem_data_out <= mem_model[mem_addr];
  end

  mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out)
  );

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    clear_req = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [127:0] d);
    req_valid[i]           = 1'b1;
    req_we[i]              = we;
    req_addr[i*8 +: 8]     = a;
    req_wdata[i*128 +: 128] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    set_req(0, 1'b1, 8'h01, 128'h1);
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0) begin
      errors++; $display("FAIL reset_mem_en: got we=%b re=%b expected 0 0", mem_write_en, mem_read_en);
    end
    step();
    step();
    checks++;
    if (rsp_valid !== 4'b0000 || clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got rsp=%b busy=%b done=%b expected 0", rsp_valid, clear_busy, clear_done);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0 || dut.state_q !== ARB) begin
      errors++; $display("FAIL reset_state: got ptr=%0d state=%0d expected 0 0", dut.rr_ptr_q, dut.state_q);
    end
    idle();
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    step();
    idle();
    set_req(2, 1'b1, 8'h10, 128'hA5);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_ready: got %b expected 0100", req_ready); end
    checks++;
    if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_addr !== 8'h10 || mem_data_in !== 128'hA5) begin
      errors++; $display("FAIL wr_port: got we=%b re=%b addr=%h data=%h expected 1 0 10 a5",
                         mem_write_en, mem_read_en, mem_addr, mem_data_in);
    end
    step();
    idle();
    set_req(2, 1'b0, 8'h10, 128'h0);
    #1;
    checks++;
    if (req_ready !== 4'b0100 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
      errors++; $display("FAIL rd_grant: got ready=%b re=%b we=%b expected 0100 1 0", req_ready, mem_read_en, mem_write_en);
    end
    step();
    idle();
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_rdata !== 128'hA5) begin
      errors++; $display("FAIL rd_rsp: got rsp=%b data=%h expected 0100 a5", rsp_valid, rsp_rdata);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_rsp_pulse: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 128'h0);
    #1;
    for (int c = 0; c < 8; c++) begin
      exp = 4'b0001 << (c % 4);
      checks++;
      if (req_ready !== exp || mem_addr !== 8'h40 + 8'(c % 4)) begin
        errors++; $display("FAIL rr_grant[%0d]: got ready=%b addr=%h expected %b %h", c, req_ready, mem_addr, exp, 8'h40 + 8'(c % 4));
      end
      step();
      checks++;
      if (rsp_valid !== exp) begin errors++; $display("FAIL rr_rsp[%0d]: got %b expected %b", c, rsp_valid, exp); end
    end
    idle();
  endtask

  task automatic test_raw_cross();
    idle();
    set_req(1, 1'b1, 8'hFF, 128'h3C);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL raw_wr_ready: got %b expected 0010", req_ready); end
    step();
    idle();
    set_req(3, 1'b0, 8'hFF, 128'h0);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL raw_rd_ready: got %b expected 1000", req_ready); end
    step();
    idle();
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_rdata !== 128'h3C) begin
      errors++; $display("FAIL raw_rsp: got rsp=%b data=%h expected 1000 3c", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_clear();
    logic [7:0] addrs [3];
    int busy_cnt, rdy_cnt, done_cnt, port_bad;
    addrs[0] = 8'h00; addrs[1] = 8'h80; addrs[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step();
      idle();
      set_req(0, 1'b1, addrs[k], 128'hDEAD_0000 + 128'(k + 1));
    end
    step();
    // Pointer is now 1; request clear with everyone reading.
    idle();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h20, 128'h0);
    clear_req = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL clr_sample_grant: got %b expected 0010", req_ready); end
    step();
    clear_req = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL clr_late_rsp: got %b expected 0010", rsp_valid); end
    busy_cnt = 0; rdy_cnt = 0; done_cnt = 0; port_bad = 0;
    for (int c = 0; c < 256; c++) begin
      if (clear_busy === 1'b1) busy_cnt++;
      if (req_ready !== 4'b0000) rdy_cnt++;
      if (clear_done === 1'b1) done_cnt++;
      if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || mem_addr !== 8'(c) || mem_data_in !== 128'h0) port_bad++;
      step();
    end
    checks++;
    if (busy_cnt !== 256) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 256", busy_cnt); end
    checks++;
    if (rdy_cnt !== 0) begin errors++; $display("FAIL clr_ready_cycles: got %0d expected 0", rdy_cnt); end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL clr_early_done: got %0d expected 0", done_cnt); end
    checks++;
    if (port_bad !== 0) begin errors++; $display("FAIL clr_port_seq: got %0d bad cycles expected 0", port_bad); end
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      errors++; $display("FAIL clr_done_pulse: got done=%b busy=%b expected 1 0", clear_done, clear_busy);
    end
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL clr_ptr_kept: got %b expected 0100", req_ready); end
    idle();
    step();
    checks++;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL clr_done_width: got %b expected 0", clear_done); end
    for (int k = 0; k < 3; k++) begin
      idle();
      set_req(0, 1'b0, addrs[k], 128'h0);
      step();
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_rdata !== 128'h0) begin
        errors++; $display("FAIL clr_readback[%h]: got rsp=%b data=%h expected 0001 0", addrs[k], rsp_valid, rsp_rdata);
      end
    end
    idle();
  endtask

  task automatic test_clear_abort();
    int done_cnt;
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (100) step();
    checks++;
    if (mem_addr !== 8'd100 || clear_busy !== 1'b1) begin
      errors++; $display("FAIL abort_pos: got addr=%0d busy=%b expected 100 1", mem_addr, clear_busy);
    end
    set_req(1, 1'b1, 8'h33, 128'h5);
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL abort_en: got we=%b re=%b ready=%b expected 0 0 0000", mem_write_en, mem_read_en, req_ready);
    end
    step();
    checks++;
    if (dut.state_q !== ARB || clear_busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin
      errors++; $display("FAIL abort_state: got state=%0d busy=%b ptr=%0d expected 0 0 0", dut.state_q, clear_busy, dut.rr_ptr_q);
    end
    idle();
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (300) begin
      step();
      if (clear_done === 1'b1 || clear_busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(3, 1'b1, 8'h05, 128'h77);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL b2b_req3: got %b expected 1000", req_ready); end
    step();
    idle();
    set_req(0, 1'b1, 8'h06, 128'h88);
    #1;
    checks++;
    if (req_ready !== 4'b0001 || mem_write_en !== 1'b1 || mem_data_in !== 128'h88) begin
      errors++; $display("FAIL b2b_req0: got ready=%b we=%b data=%h expected 0001 1 88", req_ready, mem_write_en, mem_data_in);
    end
    step();
    idle();
    checks++;
    if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL b2b_ptr: got %0d expected 1", dut.rr_ptr_q); end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_round_robin();
    test_raw_cross();
    test_clear();
    test_clear_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer in front of the switch's single-port packet buffer memory (128-bit × 256, registered read, one-cycle read latency). It shares the one memory port among NUM_REQ requesters (ingress writers, egress readers) with per-requester valid/ready handshakes. It routes read data back to the winning requester, and provides a bulk-clear sequencer that zero-fills the whole memory on command.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 128, data width, matches memory
- DEPTH, 256, memory words; ADDR_W = $clog2(DEPTH) = 8

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×ADDR_W  per-requester address
- req_wdata  in  NUM_REQ×WIDTH  per-requester write data
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse
- rsp_rdata  out  WIDTH  read data, shared by all requesters
- clear_req  in  1  start bulk clear (level sampled)
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse at clear completion
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  WIDTH  to memory data_in
- mem_write_en  out  1  to memory write_en
- mem_read_en  out  1  to memory read_en
- mem_data_out  in  WIDTH  from memory data_out

## Operation
- FSM states: ARB, CLEAR. Reset → ARB.
- ARB: combinational round-robin among asserted req_valid, starting search at pointer rr_ptr. At most one req_ready bit is high, and only for a valid requester. No valid requesters → req_ready = 0 and mem_write_en = mem_read_en = 0.
- Grant to i drives mem_addr = req_addr[i]. For a write, mem_write_en = 1 and mem_data_in = req_wdata[i]. For a read, mem_read_en = 1. The write and read enables are never both high.
- After a grant to i: rr_ptr ← (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Reads: rsp_valid[i] is registered and high in the cycle after the read grant. rsp_rdata = mem_data_out (pass-through). Requesters cannot stall responses.
- A write then a read to the same address in consecutive cycles returns the new data.
- clear_req high in ARB → next state CLEAR. Grants in the sampling cycle still occur.
- CLEAR: req_ready = 0. Address counter clr_addr runs 0..DEPTH-1, one per cycle, with mem_write_en = 1 and mem_data_in = 0. After clr_addr = DEPTH-1 → ARB, and clear_done pulses in the first ARB cycle.
- clear_req is ignored while in CLEAR. If it is still high in the cycle clear_done pulses, a new clear starts the following cycle.
- A read granted in the cycle before CLEAR still returns its rsp_valid during the first CLEAR cycle.
- rr_ptr is not changed by CLEAR.

## Timing
- Reset values: state = ARB, rr_ptr = 0, clr_addr = 0, rsp_valid = 0, clear_busy = 0, clear_done = 0, req_ready = 0. With reset_n low, all mem_* enables are 0.
- Reset asserted during CLEAR aborts it immediately. Memory contents are unspecified after an aborted clear.
- Grant/handshake latency: 0 cycles (combinational ready).
- Write commit: end of grant cycle.
- Read data: valid 1 cycle after grant.
- clear_busy: registered, equal to (state == CLEAR), high for exactly DEPTH cycles.
- Throughput: 1 access per cycle. Each continuously-valid requester is granted at least once every NUM_REQ cycles.

## Structure
- Package mem_arb_pkg: state enum arb_state_t {ARB, CLEAR}; default NUM_REQ, WIDTH, DEPTH constants; ADDR_W derivation.
- Sub-module rr_arbiter (NUM_REQ): inputs valid vector, enable, and pointer; outputs one-hot grant and encoded index. The pointer register stays in mem_arbiter.
- mem_arbiter holds the FSM, clr_addr counter, rsp_valid register, and memory-port mux.

## Test plan
- Reset, then requester 2 writes 0xA5 to addr 0x10, then reads addr 0x10 → rsp_valid[2] pulses 1 cycle after read grant, rsp_rdata = 0xA5.
- All 4 requesters hold valid (reads) for 8 cycles → grant order 0,1,2,3,0,1,2,3; each rsp_valid follows its grant by 1 cycle.
- Requester 1 writes 0x3C to addr 0xFF in cycle t; requester 3 reads 0xFF in cycle t+1 → rsp_rdata = 0x3C at t+2.
- Fill addr 0, 0x80, 0xFF with nonzero data, pulse clear_req with requesters valid → no req_ready for 256 cycles, clear_busy high 256 cycles, clear_done one pulse, then reads of 0, 0x80, 0xFF return 0.
- reset_n low at clr_addr = 100 → next cycle state ARB, clear_busy = 0, rr_ptr = 0, no clear_done pulse.
- Only requester 3 valid, then only requester 0 → immediate grant each time (no idle cycle); rr_ptr = 1 after requester 0's grant.
